// File: rtl/jaa_pkg.sv
// Shared definitions for the bytecode-to-ARM translator: opcodes, ARM encoding
// helpers and the translator state type.
package jaa_pkg;

    localparam int MAX_SEQ   = 4;
    localparam int SEQ_IDX_W = $clog2(MAX_SEQ);

    localparam logic [7:0] OP_ICONST_0 = 8'h03;
    localparam logic [7:0] OP_ICONST_5 = 8'h08;
    localparam logic [7:0] OP_BIPUSH   = 8'h10;
    localparam logic [7:0] OP_ILOAD    = 8'h15;
    localparam logic [7:0] OP_ILOAD_0  = 8'h1A;
    localparam logic [7:0] OP_ILOAD_3  = 8'h1D;
    localparam logic [7:0] OP_ISTORE   = 8'h36;
    localparam logic [7:0] OP_ISTORE_0 = 8'h3B;
    localparam logic [7:0] OP_ISTORE_3 = 8'h3E;
    localparam logic [7:0] OP_POP      = 8'h57;
    localparam logic [7:0] OP_DUP      = 8'h59;
    localparam logic [7:0] OP_SWAP     = 8'h5F;
    localparam logic [7:0] OP_IADD     = 8'h60;
    localparam logic [7:0] OP_ISUB     = 8'h64;

    localparam logic [31:0] PFX_PUSH = 32'hE92D0000;
    localparam logic [31:0] PFX_POP  = 32'hE8BD0000;
    localparam logic [31:0] PFX_MOV  = 32'hE3A00000;
    localparam logic [31:0] PFX_MVN  = 32'hE3E00000;
    localparam logic [31:0] PFX_LDR  = 32'hE5900000;
    localparam logic [31:0] PFX_STR  = 32'hE5800000;
    localparam logic [31:0] PFX_ADD  = 32'hE0800000;
    localparam logic [31:0] PFX_SUB  = 32'hE0400000;

    typedef enum logic [1:0] {
        ST_OPCODE,
        ST_OPERAND,
        ST_EMIT
    } state_e;

    function automatic logic inRange(input logic [7:0] op, input logic [7:0] lo,
                                     input logic [7:0] hi);
        return (op >= lo) && (op <= hi);
    endfunction

    function automatic logic [31:0] enc_push(input logic [15:0] mask);
        return PFX_PUSH | {16'h0000, mask};
    endfunction

    function automatic logic [31:0] enc_pop(input logic [15:0] mask);
        return PFX_POP | {16'h0000, mask};
    endfunction

    function automatic logic [31:0] enc_mov(input logic [3:0] r, input logic [7:0] imm);
        return PFX_MOV | {16'h0000, r, 4'h0, imm};
    endfunction

    function automatic logic [31:0] enc_mvn(input logic [3:0] r, input logic [7:0] imm);
        return PFX_MVN | {16'h0000, r, 4'h0, imm};
    endfunction

    function automatic logic [31:0] enc_ldst(input logic isLoad, input logic [3:0] f,
                                             input logic [3:0] r, input logic [11:0] off);
        return (isLoad ? PFX_LDR : PFX_STR) | {12'h000, f, r, off};
    endfunction

    function automatic logic [31:0] enc_alu(input logic isSub, input logic [3:0] r,
                                            input logic [3:0] t);
        return (isSub ? PFX_SUB : PFX_ADD) | {12'h000, r, r, 8'h00, t};
    endfunction

    function automatic logic needsOperand(input logic [7:0] op);
        return (op == OP_BIPUSH) || (op == OP_ILOAD) || (op == OP_ISTORE);
    endfunction

    function automatic logic isZeroOperand(input logic [7:0] op);
        return inRange(op, OP_ICONST_0, OP_ICONST_5) || inRange(op, OP_ILOAD_0, OP_ILOAD_3) ||
               inRange(op, OP_ISTORE_0, OP_ISTORE_3) || (op == OP_POP) || (op == OP_DUP) ||
               (op == OP_SWAP) || (op == OP_IADD) || (op == OP_ISUB);
    endfunction

endpackage

// File: rtl/jaa_seq_gen.sv
// Combinational sequence table: picks word k of the ARM expansion of one bytecode
// and flags whether it is the final word.
module jaa_seq_gen
    import jaa_pkg::*;
#(
    parameter logic [3:0] VAL_REG    = 4'd1,
    parameter logic [3:0] TMP_REG    = 4'd2,
    parameter logic [3:0] FRAME_REG  = 4'd11,
    parameter int         SLOT_SHIFT = 2
) (
    input  logic [7:0]           opcode_i,
    input  logic [7:0]           operand_i,
    input  logic [SEQ_IDX_W-1:0] k_i,
    output logic [31:0]          word_o,
    output logic                 last_o
);

    localparam logic [15:0] R_MASK = 16'h0001 << VAL_REG;
    localparam logic [15:0] T_MASK = 16'h0001 << TMP_REG;

    logic [7:0]  idx;
    logic [11:0] offset;

    // Short-form loads/stores carry the slot index in the opcode itself.
    always_comb begin
        idx = operand_i;
        if (inRange(opcode_i, OP_ILOAD_0, OP_ILOAD_3)) begin
            idx = opcode_i - OP_ILOAD_0;
        end else if (inRange(opcode_i, OP_ISTORE_0, OP_ISTORE_3)) begin
            idx = opcode_i - OP_ISTORE_0;
        end
    end

    assign offset = {4'h0, idx} << SLOT_SHIFT;

    always_comb begin
        word_o = '0;
        last_o = 1'b1;
        if (inRange(opcode_i, OP_ICONST_0, OP_ICONST_5)) begin
            if (k_i == '0) begin
                word_o = enc_mov(VAL_REG, opcode_i - OP_ICONST_0);
                last_o = 1'b0;
            end else begin
                word_o = enc_push(R_MASK);
            end
        end else if (opcode_i == OP_BIPUSH) begin
            if (k_i == '0) begin
                word_o = operand_i[7] ? enc_mvn(VAL_REG, ~operand_i) : enc_mov(VAL_REG, operand_i);
                last_o = 1'b0;
            end else begin
                word_o = enc_push(R_MASK);
            end
        end else if ((opcode_i == OP_ILOAD) || inRange(opcode_i, OP_ILOAD_0, OP_ILOAD_3)) begin
            if (k_i == '0) begin
                word_o = enc_ldst(1'b1, FRAME_REG, VAL_REG, offset);
                last_o = 1'b0;
            end else begin
                word_o = enc_push(R_MASK);
            end
        end else if ((opcode_i == OP_ISTORE) || inRange(opcode_i, OP_ISTORE_0, OP_ISTORE_3)) begin
            if (k_i == '0) begin
                word_o = enc_pop(R_MASK);
                last_o = 1'b0;
            end else begin
                word_o = enc_ldst(1'b0, FRAME_REG, VAL_REG, offset);
            end
        end else if ((opcode_i == OP_IADD) || (opcode_i == OP_ISUB)) begin
            last_o = (k_i == 2'd3);
            case (k_i)
                2'd0:    word_o = enc_pop(T_MASK);
                2'd1:    word_o = enc_pop(R_MASK);
                2'd2:    word_o = enc_alu(opcode_i == OP_ISUB, VAL_REG, TMP_REG);
                default: word_o = enc_push(R_MASK);
            endcase
        end else if (opcode_i == OP_POP) begin
            word_o = enc_pop(R_MASK);
        end else if (opcode_i == OP_DUP) begin
            last_o = (k_i >= 2'd2);
            word_o = (k_i == '0) ? enc_pop(R_MASK) : enc_push(R_MASK);
        end else if (opcode_i == OP_SWAP) begin
            last_o = (k_i == 2'd3);
            case (k_i)
                2'd0:    word_o = enc_pop(R_MASK);
                2'd1:    word_o = enc_pop(T_MASK);
                2'd2:    word_o = enc_push(R_MASK);
                default: word_o = enc_push(T_MASK);
            endcase
        end
    end

endmodule

// File: rtl/jaa_stream_translator.sv
// Streaming bytecode-to-ARM translator: byte-wide valid/ready in, one ARM word
// per cycle out, with unsupported-opcode reporting and an emitted-word counter.
module jaa_stream_translator
    import jaa_pkg::*;
#(
    parameter logic [3:0] VAL_REG    = 4'd1,
    parameter logic [3:0] TMP_REG    = 4'd2,
    parameter logic [3:0] FRAME_REG  = 4'd11,
    parameter int         SLOT_SHIFT = 2,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bc_valid,
    output logic             bc_ready,
    input  logic [7:0]       bc_data,
    output logic             arm_valid,
    input  logic             arm_ready,
    output logic [31:0]      arm_instr,
    output logic             arm_last,
    output logic             unsup_pulse,
    output logic [7:0]       unsup_opcode,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e               state_q;
    logic [7:0]           opcode_q, operand_q, unsup_opcode_q;
    logic [SEQ_IDX_W-1:0] k_q;
    logic                 arm_valid_q, arm_last_q, unsup_pulse_q;
    logic [31:0]          arm_instr_q;
    logic [CNT_W-1:0]     count_q;

    logic [7:0]           gen_op_d, gen_operand_d;
    logic [SEQ_IDX_W-1:0] gen_k_d;
    logic [31:0]          gen_word;
    logic                 gen_last;

    // The generator looks one word ahead so the output word can be registered.
    always_comb begin
        gen_op_d      = opcode_q;
        gen_operand_d = operand_q;
        gen_k_d       = k_q;
        case (state_q)
            ST_OPCODE: begin
                gen_op_d      = bc_data;
                gen_operand_d = '0;
                gen_k_d       = '0;
            end
            ST_OPERAND: begin
                gen_operand_d = bc_data;
                gen_k_d       = '0;
            end
            default: gen_k_d = k_q + 1'b1;
        endcase
    end

    jaa_seq_gen #(
        .VAL_REG   (VAL_REG),
        .TMP_REG   (TMP_REG),
        .FRAME_REG (FRAME_REG),
        .SLOT_SHIFT(SLOT_SHIFT)
    ) u_seq_gen (
        .opcode_i (gen_op_d),
        .operand_i(gen_operand_d),
        .k_i      (gen_k_d),
        .word_o   (gen_word),
        .last_o   (gen_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_OPCODE;
            opcode_q       <= '0;
            operand_q      <= '0;
            k_q            <= '0;
            arm_valid_q    <= 1'b0;
            arm_last_q     <= 1'b0;
            arm_instr_q    <= '0;
            unsup_pulse_q  <= 1'b0;
            unsup_opcode_q <= '0;
            count_q        <= '0;
        end else begin
            unsup_pulse_q <= 1'b0;
            case (state_q)
                ST_OPCODE: begin
                    if (bc_valid) begin
                        opcode_q <= bc_data;
                        if (needsOperand(bc_data)) begin
                            state_q <= ST_OPERAND;
                        end else if (isZeroOperand(bc_data)) begin
                            state_q     <= ST_EMIT;
                            k_q         <= '0;
                            arm_valid_q <= 1'b1;
                            arm_instr_q <= gen_word;
                            arm_last_q  <= gen_last;
                        end else begin
                            unsup_pulse_q  <= 1'b1;
                            unsup_opcode_q <= bc_data;
                        end
                    end
                end
                ST_OPERAND: begin
                    if (bc_valid) begin
                        operand_q   <= bc_data;
                        state_q     <= ST_EMIT;
                        k_q         <= '0;
                        arm_valid_q <= 1'b1;
                        arm_instr_q <= gen_word;
                        arm_last_q  <= gen_last;
                    end
                end
                default: begin
                    if (arm_ready) begin
                        count_q <= count_q + CNT_ONE;
                        if (arm_last_q) begin
                            state_q     <= ST_OPCODE;
                            arm_valid_q <= 1'b0;
                            arm_last_q  <= 1'b0;
                            arm_instr_q <= '0;
                        end else begin
                            k_q         <= gen_k_d;
                            arm_instr_q <= gen_word;
                            arm_last_q  <= gen_last;
                        end
                    end
                end
            endcase
        end
    end

    // Held low for the whole reset so no byte is taken while state is undefined.
    assign bc_ready     = ~reset && (state_q != ST_EMIT);
    assign arm_valid    = arm_valid_q;
    assign arm_instr    = arm_instr_q;
    assign arm_last     = arm_last_q;
    assign unsup_pulse  = unsup_pulse_q;
    assign unsup_opcode = unsup_opcode_q;
    assign instr_count  = count_q;

endmodule

// File: tb/tb_jaa_stream_translator.sv
// Self-checking bench: directed bytecode sequences plus randomized programs
// compared against a word-list reference model.
module tb_jaa_stream_translator;

    localparam int R_REG = 1;
    localparam int T_REG = 2;
    localparam int F_REG = 11;
    localparam int SHIFT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        bc_valid;
    logic        bc_ready;
    logic [7:0]  bc_data;
    logic        arm_valid;
    logic        arm_ready;
    logic [31:0] arm_instr;
    logic        arm_last;
    logic        unsup_pulse;
    logic [7:0]  unsup_opcode;
    logic [15:0] instr_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ[$];
    int          modelCount = 0;
    logic [7:0]  modelUnsup = 8'h00;
    logic [7:0]  supportedOps[24];
    logic [7:0]  unsupportedOps[4];

    always #5 clk = ~clk;

    jaa_stream_translator dut (
        .clk         (clk),
        .reset       (reset),
        .bc_valid    (bc_valid),
        .bc_ready    (bc_ready),
        .bc_data     (bc_data),
        .arm_valid   (arm_valid),
        .arm_ready   (arm_ready),
        .arm_instr   (arm_instr),
        .arm_last    (arm_last),
        .unsup_pulse (unsup_pulse),
        .unsup_opcode(unsup_opcode),
        .instr_count (instr_count)
    );

    // Reference encodings built straight from the ARM field layout.
    function automatic logic [31:0] mPush(input int r);
        return 32'hE92D0000 + (32'd1 << r);
    endfunction
    function automatic logic [31:0] mPop(input int r);
        return 32'hE8BD0000 + (32'd1 << r);
    endfunction
    function automatic logic [31:0] mLdSt(input bit ld, input int idx);
        int off;
        off = (idx * (1 << SHIFT)) % 4096;
        return (ld ? 32'hE5900000 : 32'hE5800000) + F_REG * 65536 + R_REG * 4096 + off;
    endfunction
    function automatic logic [31:0] mImm(input int value);
        if (value >= 0) return 32'hE3A00000 + R_REG * 4096 + value;
        return 32'hE3E00000 + R_REG * 4096 + (-value - 1);
    endfunction
    function automatic logic [31:0] mAlu(input bit isSub);
        return (isSub ? 32'hE0400000 : 32'hE0800000) + R_REG * 65536 + R_REG * 4096 + T_REG;
    endfunction

    function automatic bit hasOperand(input logic [7:0] op);
        return (op == 8'h10) || (op == 8'h15) || (op == 8'h36);
    endfunction

    function automatic void buildExpected(input logic [7:0] op, input logic [7:0] opnd);
        int signedByte;
        expQ.delete();
        signedByte = int'($signed(opnd));
        if (op >= 8'h03 && op <= 8'h08) begin
            expQ.push_back(mImm(int'(op) - 3)); expQ.push_back(mPush(R_REG));
        end else if (op == 8'h10) begin
            expQ.push_back(mImm(signedByte)); expQ.push_back(mPush(R_REG));
        end else if (op == 8'h15 || (op >= 8'h1A && op <= 8'h1D)) begin
            expQ.push_back(mLdSt(1'b1, (op == 8'h15) ? int'(opnd) : int'(op) - 8'h1A));
            expQ.push_back(mPush(R_REG));
        end else if (op == 8'h36 || (op >= 8'h3B && op <= 8'h3E)) begin
            expQ.push_back(mPop(R_REG));
            expQ.push_back(mLdSt(1'b0, (op == 8'h36) ? int'(opnd) : int'(op) - 8'h3B));
        end else if (op == 8'h60 || op == 8'h64) begin
            expQ.push_back(mPop(T_REG)); expQ.push_back(mPop(R_REG));
            expQ.push_back(mAlu(op == 8'h64)); expQ.push_back(mPush(R_REG));
        end else if (op == 8'h57) begin
            expQ.push_back(mPop(R_REG));
        end else if (op == 8'h59) begin
            expQ.push_back(mPop(R_REG)); expQ.push_back(mPush(R_REG)); expQ.push_back(mPush(R_REG));
        end else if (op == 8'h5F) begin
            expQ.push_back(mPop(R_REG)); expQ.push_back(mPop(T_REG));
            expQ.push_back(mPush(R_REG)); expQ.push_back(mPush(T_REG));
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        checkOutput("bc_ready_idle", {31'd0, bc_ready}, 32'd1);
        bc_valid = 1'b1;
        bc_data  = b;
        @(posedge clk); #1;
        bc_valid = 1'b0;
        bc_data  = 8'h00;
    endtask

    task automatic drainWords(input int stallWord, input int stallCycles);
        logic [31:0] held;
        logic        heldLast;
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput("arm_valid", {31'd0, arm_valid}, 32'd1);
            checkOutput("bc_ready_emit", {31'd0, bc_ready}, 32'd0);
            if (i == stallWord && stallCycles > 0) begin
                arm_ready = 1'b0;
                held      = arm_instr;
                heldLast  = arm_last;
                for (int s = 0; s < stallCycles; s++) begin
                    @(posedge clk); #1;
                    checkOutput("stall_instr", arm_instr, held);
                    checkOutput("stall_last", {31'd0, arm_last}, {31'd0, heldLast});
                    checkOutput("stall_valid", {31'd0, arm_valid}, 32'd1);
                    checkOutput("stall_bc_ready", {31'd0, bc_ready}, 32'd0);
                end
                arm_ready = 1'b1;
            end
            checkOutput("arm_instr", arm_instr, expQ[i]);
            checkOutput("arm_last", {31'd0, arm_last}, (i == expQ.size() - 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            modelCount = (modelCount + 1) % 65536;
        end
        checkOutput("done_valid", {31'd0, arm_valid}, 32'd0);
        checkOutput("done_bc_ready", {31'd0, bc_ready}, 32'd1);
        checkOutput("instr_count", {16'd0, instr_count}, modelCount);
        checkOutput("unsup_held", {24'd0, unsup_opcode}, {24'd0, modelUnsup});
    endtask

    task automatic runBytecode(input logic [7:0] op, input logic [7:0] opnd,
                               input int stallWord, input int stallCycles);
        buildExpected(op, opnd);
        applyStimulus(op);
        if (hasOperand(op)) applyStimulus(opnd);
        drainWords(stallWord, stallCycles);
    endtask

    task automatic runUnsupported(input logic [7:0] op);
        applyStimulus(op);
        modelUnsup = op;
        checkOutput("unsup_pulse_on", {31'd0, unsup_pulse}, 32'd1);
        checkOutput("unsup_opcode", {24'd0, unsup_opcode}, {24'd0, op});
        checkOutput("unsup_no_word", {31'd0, arm_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("unsup_pulse_off", {31'd0, unsup_pulse}, 32'd0);
        checkOutput("unsup_opcode_hold", {24'd0, unsup_opcode}, {24'd0, op});
        checkOutput("unsup_bc_ready", {31'd0, bc_ready}, 32'd1);
    endtask

    initial begin
        supportedOps = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h10, 8'h15,
                         8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h36, 8'h3B, 8'h3C, 8'h3D,
                         8'h3E, 8'h57, 8'h59, 8'h5F, 8'h60, 8'h64, 8'h10, 8'h15};
        unsupportedOps = '{8'h00, 8'hB1, 8'hFF, 8'h2A};
        reset     = 1'b1;
        bc_valid  = 1'b0;
        bc_data   = 8'h00;
        arm_ready = 1'b1;
        #12;
        checkOutput("rst_bc_ready", {31'd0, bc_ready}, 32'd0);
        checkOutput("rst_arm_valid", {31'd0, arm_valid}, 32'd0);
        checkOutput("rst_arm_last", {31'd0, arm_last}, 32'd0);
        checkOutput("rst_arm_instr", arm_instr, 32'd0);
        checkOutput("rst_unsup_pulse", {31'd0, unsup_pulse}, 32'd0);
        checkOutput("rst_unsup_opcode", {24'd0, unsup_opcode}, 32'd0);
        checkOutput("rst_count", {16'd0, instr_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_bc_ready", {31'd0, bc_ready}, 32'd1);
        @(posedge clk); #1;

        // Directed sequences.
        runBytecode(8'h04, 8'h00, -1, 0);
        runBytecode(8'h3C, 8'h00, -1, 0);
        checkOutput("count_after_4", {16'd0, instr_count}, 32'd4);
        runBytecode(8'h10, 8'hFE, -1, 0);
        runBytecode(8'h15, 8'hFF, -1, 0);
        runBytecode(8'h36, 8'h00, -1, 0);
        runBytecode(8'h60, 8'h00, 1, 3);
        runUnsupported(8'hB1);
        runBytecode(8'h5F, 8'h00, -1, 0);
        runBytecode(8'h10, 8'h7F, 0, 1);
        runBytecode(8'h10, 8'h80, -1, 0);

        // Reset in the middle of an iadd sequence abandons it.
        applyStimulus(8'h60);
        checkOutput("iadd_w1", arm_instr, mPop(T_REG));
        @(posedge clk); #1;
        arm_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_valid", {31'd0, arm_valid}, 32'd0);
        checkOutput("midrst_bc_ready", {31'd0, bc_ready}, 32'd0);
        checkOutput("midrst_count", {16'd0, instr_count}, 32'd0);
        checkOutput("midrst_unsup", {24'd0, unsup_opcode}, 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        arm_ready  = 1'b1;
        modelCount = 0;
        modelUnsup = 8'h00;
        @(posedge clk); #1;
        checkOutput("after_rst_valid", {31'd0, arm_valid}, 32'd0);
        runBytecode(8'h03, 8'h00, -1, 0);

        // Randomized programs with random backpressure.
        for (int it = 0; it < 60; it++) begin
            int pick;
            logic [7:0] op;
            logic [7:0] opnd;
            pick = int'($urandom_range(0, 27));
            opnd = 8'($urandom_range(0, 255));
            if (pick >= 24) begin
                op = unsupportedOps[pick - 24];
                runUnsupported(op);
            end else begin
                op = supportedOps[pick];
                runBytecode(op, opnd, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
